uart_rx: RTL



---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_ff.sv | 28 ++
 rtl/uart_rx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and frame helpers
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Total line bits in one frame, start bit included.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != int'(PARITY_NONE)) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - N-stage flop synchronizer for an asynchronous input
module sync_ff #(
    parameter int   Stages     = 2,
    parameter logic ResetValue = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    if (Stages < 2) begin : g_chk_stages
        $error("sync_ff: Stages must be >= 2");
    end

    logic [Stages-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {Stages{ResetValue}};
        end else begin
            r_sync <= {r_sync[Stages-2:0], i_d};
        end
    end

    assign o_q = r_sync[Stages-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: centre-sampled frames delivered over valid/ready
module uart_rx
    import uart_pkg::*;
#(
    parameter int BaudDivider = 8,
    parameter int DataBits    = 8,
    parameter int StopBits    = 1,
    parameter int Parity      = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_in,
    output logic [DataBits-1:0] data_out,
    output logic                data_out_valid,
    input  logic                data_out_ready,
    output logic                parity_error,
    output logic                frame_error,
    output logic                overrun,
    output logic                busy
);

    if (BaudDivider < 4) begin : g_chk_baud
        $error("uart_rx: BaudDivider must be >= 4");
    end
    if (DataBits < 5 || DataBits > 9) begin : g_chk_data
        $error("uart_rx: DataBits must be 5..9");
    end
    if (StopBits < 1 || StopBits > 2) begin : g_chk_stop
        $error("uart_rx: StopBits must be 1 or 2");
    end
    if (Parity < int'(PARITY_NONE) || Parity > int'(PARITY_ODD)) begin : g_chk_parity
        $error("uart_rx: Parity must be 0, 1 or 2");
    end

    localparam int CNT_W = $clog2(BaudDivider);
    localparam int BIT_W = $clog2(DataBits + 2);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BaudDivider / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BaudDivider - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DataBits - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(StopBits - 1);
    localparam bit PAR_EN  = (Parity != int'(PARITY_NONE));
    localparam bit PAR_ODD = (Parity == int'(PARITY_ODD));

    rx_state_t           r_state;
    rx_state_t           w_next;
    logic                w_rx_s;
    logic                r_prev;
    logic [CNT_W-1:0]    r_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [DataBits-1:0] r_shift;
    logic                r_par_bit;
    logic                r_ferr;
    logic                r_done;
    logic                w_start_edge;
    logic                w_half;
    logic                w_full;
    logic                w_last_data;
    logic                w_last_stop;
    logic                w_sample;
    logic                w_frame_done;
    logic                w_par_xor;
    logic                w_par_err;

    sync_ff #(
        .Stages    (2),
        .ResetValue(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .i_d  (rx_in),
        .o_q  (w_rx_s)
    );

    // Start needs a seen high-to-low edge, so a held-low line never retriggers.
    assign w_start_edge = r_prev & ~w_rx_s;
    assign w_half       = (r_cnt == HALF_LAST);
    assign w_full       = (r_cnt == FULL_LAST);
    assign w_last_data  = (r_bit_cnt == DATA_LAST);
    assign w_last_stop  = (r_bit_cnt == STOP_LAST);
    assign w_par_xor    = ^{r_shift, r_par_bit};
    assign w_par_err    = PAR_EN && (w_par_xor ^ PAR_ODD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_edge) w_next = START;
            START:   if (w_half) w_next = w_rx_s ? IDLE : DATA;
            DATA:    if (w_full && w_last_data) w_next = PAR_EN ? PARITY : STOP;
            PARITY:  if (w_full) w_next = STOP;
            STOP:    if (w_full && w_last_stop) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_sample = 1'b0;
        case (r_state)
            START:              w_sample = w_half;
            DATA, PARITY, STOP: w_sample = w_full;
            default:            w_sample = 1'b0;
        endcase
        w_frame_done = (r_state == STOP) && w_full && w_last_stop;
        busy         = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev    <= 1'b1;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_ferr    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_prev <= w_rx_s;
            r_done <= w_frame_done;
            if (r_state == IDLE || w_sample) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == IDLE && w_start_edge) begin
                r_ferr <= 1'b0;
            end
            if (w_sample) begin
                case (r_state)
                    START: r_bit_cnt <= '0;
                    DATA: begin
                        r_shift   <= {w_rx_s, r_shift[DataBits-1:1]};
                        r_bit_cnt <= w_last_data ? '0 : r_bit_cnt + 1'b1;
                    end
                    PARITY: r_par_bit <= w_rx_s;
                    STOP: begin
                        if (!w_rx_s) begin
                            r_ferr <= 1'b1;
                        end
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A completing frame replaces the word only if the slot is empty or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            parity_error   <= 1'b0;
            frame_error    <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (r_done) begin
                if (!data_out_valid || data_out_ready) begin
                    data_out       <= r_shift;
                    parity_error   <= w_par_err;
                    frame_error    <= r_ferr;
                    data_out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule
